// File: rtl/bootprom_ctl.sv
// Bus-cycle sequencer between the 68010 bus and the 27256 boot PROM pair.
// Optional BOOTPROM_WRITE_BERR_EN: writes to the PROM region raise BERR instead of a silent DTACK.
module bootprom_ctl #(
    parameter int WAIT_STATES = 3,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_as_n,
    input  logic        cpu_rw,
    input  logic        cpu_uds_n,
    input  logic        cpu_lds_n,
    input  logic [14:0] cpu_addr,
    input  logic        prom_sel,
    output logic [14:0] prom_addr,
    output logic        prom_ce_n,
    output logic        prom_oe_n,
    input  logic [7:0]  prom_lo_d,
    input  logic [7:0]  prom_hi_d,
    output logic [15:0] cpu_data_out,
    output logic        cpu_data_oe,
    output logic        cpu_dtack_n,
    output logic        cpu_berr_n
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        ACK,
        WDONE,
        WERR
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [14:0]       addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              start;

    // Byte strobes only qualify the cycle; both PROM bytes are always read.
    assign start = !cpu_as_n && prom_sel && (!cpu_uds_n || !cpu_lds_n);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cpu_rw) begin
                        addr_d  = cpu_addr;
                        state_d = SETUP;
                    end else begin
`ifdef BOOTPROM_WRITE_BERR_EN
                        state_d = WERR;
`else
                        state_d = WDONE;
`endif
                    end
                end
            end
            SETUP: begin
                if (cpu_as_n) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = CNT_W'(WAIT_STATES - 1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // An abort wins over a latch due on the same edge.
                if (cpu_as_n) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    data_d  = {prom_hi_d, prom_lo_d};
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK, WDONE, WERR: begin
                if (cpu_as_n) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign prom_addr    = addr_q;
    assign cpu_data_out = data_q;
    assign prom_ce_n    = !(state_q == SETUP || state_q == ACCESS || state_q == ACK);
    assign prom_oe_n    = !(state_q == ACCESS || state_q == ACK);
    assign cpu_data_oe  = (state_q == ACK);
    assign cpu_dtack_n  = !(state_q == ACK || state_q == WDONE);
`ifdef BOOTPROM_WRITE_BERR_EN
    assign cpu_berr_n   = (state_q != WERR);
`else
    assign cpu_berr_n   = 1'b1;
`endif

endmodule

// File: tb/tb_bootprom_ctl.sv
// Scoreboard bench for bootprom_ctl: stimulus queues expected DTACK responses,
// a monitor pops and checks them whenever DTACK falls.
module tb_bootprom_ctl;

    localparam int WS = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_as_n = 1'b1;
    logic        cpu_rw = 1'b1;
    logic        cpu_uds_n = 1'b1;
    logic        cpu_lds_n = 1'b1;
    logic [14:0] cpu_addr = '0;
    logic        prom_sel = 1'b0;
    logic [14:0] prom_addr;
    logic        prom_ce_n;
    logic        prom_oe_n;
    logic [7:0]  prom_lo_d = '0;
    logic [7:0]  prom_hi_d = '0;
    logic [15:0] cpu_data_out;
    logic        cpu_data_oe;
    logic        cpu_dtack_n;
    logic        cpu_berr_n;

    bootprom_ctl #(.WAIT_STATES(WS), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_as_n     (cpu_as_n),
        .cpu_rw       (cpu_rw),
        .cpu_uds_n    (cpu_uds_n),
        .cpu_lds_n    (cpu_lds_n),
        .cpu_addr     (cpu_addr),
        .prom_sel     (prom_sel),
        .prom_addr    (prom_addr),
        .prom_ce_n    (prom_ce_n),
        .prom_oe_n    (prom_oe_n),
        .prom_lo_d    (prom_lo_d),
        .prom_hi_d    (prom_hi_d),
        .cpu_data_out (cpu_data_out),
        .cpu_data_oe  (cpu_data_oe),
        .cpu_dtack_n  (cpu_dtack_n),
        .cpu_berr_n   (cpu_berr_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_read;
        logic [15:0] data;
        logic [14:0] addr;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: counts edges with AS low and checks each DTACK against the queue.
    initial begin
        int   cyc;
        logic prev_dtack;
        exp_t e;
        cyc = 0;
        prev_dtack = 1'b1;
        forever begin
            @(posedge clk);
            if (!cpu_as_n && !reset) cyc++;
            else cyc = 0;
            #1;
            if (prev_dtack && !cpu_dtack_n) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_dtack", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("dtack_latency", cyc, e.lat);
                    if (e.is_read) begin
                        chk("read_data", cpu_data_out, e.data);
                        chk("read_prom_addr", prom_addr, e.addr);
                        chk("read_data_oe", cpu_data_oe, 1);
                    end else begin
                        chk("write_data_oe", cpu_data_oe, 0);
                        chk("write_ce_n", prom_ce_n, 1);
                    end
                    $display("txn %s addr=0x%0h data=0x%0h latency=%0d",
                             e.is_read ? "read" : "write", prom_addr, cpu_data_out, cyc);
                end
            end
            prev_dtack = cpu_dtack_n;
        end
    end

    task automatic start_cycle(input bit rw, input logic [14:0] a, input bit sel);
        @(negedge clk);
        cpu_as_n  = 1'b0;
        cpu_rw    = rw;
        cpu_uds_n = 1'b0;
        cpu_lds_n = 1'b0;
        cpu_addr  = a;
        prom_sel  = sel;
    endtask

    task automatic release_as();
        cpu_as_n  = 1'b1;
        cpu_uds_n = 1'b1;
        cpu_lds_n = 1'b1;
        prom_sel  = 1'b0;
        @(negedge clk);
        chk("idle_after_release_dtack_n", cpu_dtack_n, 1);
        chk("idle_after_release_ce_n", prom_ce_n, 1);
        chk("idle_after_release_data_oe", cpu_data_oe, 0);
    endtask

    task automatic wait_dtack(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!cpu_dtack_n) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_read(input logic [14:0] a, input logic [7:0] lo, input logic [7:0] hi);
        exp_t e;
        prom_lo_d = lo;
        prom_hi_d = hi;
        e.is_read = 1'b1;
        e.data    = {hi, lo};
        e.addr    = a;
        e.lat     = WS + 2;
        exp_q.push_back(e);
        start_cycle(1'b1, a, 1'b1);
        wait_dtack("read");
        release_as();
    endtask

    initial begin
        exp_t e;
        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_ce_n", prom_ce_n, 1);
        chk("reset_oe_n", prom_oe_n, 1);
        chk("reset_dtack_n", cpu_dtack_n, 1);
        chk("reset_berr_n", cpu_berr_n, 1);
        chk("reset_data_out", cpu_data_out, 16'h0000);
        chk("reset_data_oe", cpu_data_oe, 0);
        chk("reset_prom_addr", prom_addr, 15'h0000);
        reset = 1'b0;

        // Basic read
        do_read(15'h0004, 8'h4E, 8'hF9);

        // Aborted read: AS released after two edges
        prom_lo_d = 8'h11;
        prom_hi_d = 8'h22;
        start_cycle(1'b1, 15'h0200, 1'b1);
        repeat (2) @(negedge clk);
        chk("abort_oe_n_active", prom_oe_n, 0);
        cpu_as_n = 1'b1;
        cpu_uds_n = 1'b1;
        cpu_lds_n = 1'b1;
        @(negedge clk);
        chk("abort_ce_n", prom_ce_n, 1);
        chk("abort_oe_n", prom_oe_n, 1);
        repeat (6) @(negedge clk);
        chk("abort_dtack_n", cpu_dtack_n, 1);
        chk("abort_data_kept", cpu_data_out, 16'hF94E);

        // Back-to-back reads at the address extremes
        do_read(15'h0000, 8'hA5, 8'h3C);
        do_read(15'h7FFF, 8'h81, 8'h7E);

        // Write to the PROM region
`ifdef BOOTPROM_WRITE_BERR_EN
        start_cycle(1'b0, 15'h0010, 1'b1);
        repeat (3) @(negedge clk);
        chk("werr_berr_n", cpu_berr_n, 0);
        chk("werr_dtack_n", cpu_dtack_n, 1);
        chk("werr_ce_n", prom_ce_n, 1);
        release_as();
        chk("werr_berr_released", cpu_berr_n, 1);
`else
        e.is_read = 1'b0;
        e.data    = '0;
        e.addr    = '0;
        e.lat     = 1;
        exp_q.push_back(e);
        start_cycle(1'b0, 15'h0010, 1'b1);
        wait_dtack("write");
        repeat (2) @(negedge clk);
        chk("write_ce_n_held", prom_ce_n, 1);
        chk("write_berr_n", cpu_berr_n, 1);
        release_as();
`endif

        // Read outside the PROM region: no activity
        start_cycle(1'b1, 15'h0044, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (prom_ce_n !== 1'b1 || cpu_dtack_n !== 1'b1) begin
                chk("nosel_ce_n", prom_ce_n, 1);
                chk("nosel_dtack_n", cpu_dtack_n, 1);
            end
        end
        chk("nosel_ce_n_end", prom_ce_n, 1);
        chk("nosel_dtack_n_end", cpu_dtack_n, 1);
        cpu_as_n = 1'b1;
        cpu_uds_n = 1'b1;
        cpu_lds_n = 1'b1;

        // Reset mid-ACCESS
        prom_lo_d = 8'h55;
        prom_hi_d = 8'hAA;
        start_cycle(1'b1, 15'h0123, 1'b1);
        repeat (3) @(negedge clk);
        chk("pre_reset_oe_n", prom_oe_n, 0);
        reset = 1'b1;
        #1;
        chk("midreset_ce_n", prom_ce_n, 1);
        chk("midreset_oe_n", prom_oe_n, 1);
        chk("midreset_dtack_n", cpu_dtack_n, 1);
        chk("midreset_data_out", cpu_data_out, 16'h0000);
        chk("midreset_prom_addr", prom_addr, 15'h0000);
        cpu_as_n = 1'b1;
        cpu_uds_n = 1'b1;
        cpu_lds_n = 1'b1;
        prom_sel = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_reset_ce_n", prom_ce_n, 1);
        chk("post_reset_dtack_n", cpu_dtack_n, 1);

        // A read after reset must still work
        do_read(15'h1234, 8'h0F, 8'hE1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bootprom_ctl.md
Name: bootprom_ctl

Overview:
- Bus-cycle sequencer between the 68010 CPU bus and the boot PROM pair: low-byte (D7..D0) and high-byte (D15..D8) 27256 devices.
- Decodes a selected PROM read, drives the shared PROM address, CE_n and OE_n, and waits a programmable access time.
- Latches both PROM bytes into a 16-bit word and returns it to the CPU with DTACK_n.
- Sits directly upstream of the 27256 models and consumes their O0..O7 outputs.

Parameters:
- WAIT_STATES, 3, clk cycles OE_n is held low before data is latched; legal range 1..15.
- CNT_W, 4, width of the wait counter; must hold WAIT_STATES.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- cpu_as_n  input  1  CPU address strobe, already synchronised to clk
- cpu_rw  input  1  1=read, 0=write
- cpu_uds_n  input  1  upper data strobe
- cpu_lds_n  input  1  lower data strobe
- cpu_addr  input  15  CPU word address A15..A1
- prom_sel  input  1  address decode hit for the boot PROM region
- prom_addr  output  15  to A14..A0 of both PROMs
- prom_ce_n  output  1  to CE_n of both PROMs
- prom_oe_n  output  1  to OE_n of both PROMs
- prom_lo_d  input  8  O7..O0 of the low-byte PROM
- prom_hi_d  input  8  O7..O0 of the high-byte PROM
- cpu_data_out  output  16  latched word {hi,lo}
- cpu_data_oe  output  1  enable for driving cpu_data_out onto the CPU bus
- cpu_dtack_n  output  1  data acknowledge
- cpu_berr_n  output  1  bus error (used only with the optional feature)

Behaviour:
- Reset values:
  - prom_addr=0, prom_ce_n=1, prom_oe_n=1.
  - cpu_data_out=16'h0000, cpu_data_oe=0.
  - cpu_dtack_n=1, cpu_berr_n=1.
  - State=IDLE, counter=0.
- Reset is asynchronous and overrides everything. Reset asserted mid-cycle returns to IDLE immediately with all outputs at reset values.
- FSM states:
  - IDLE
    - Cycle start condition: cpu_as_n=0 and prom_sel=1 and (cpu_uds_n=0 or cpu_lds_n=0).
    - If the start condition holds with cpu_rw=1: register prom_addr<=cpu_addr, go SETUP.
    - If it holds with cpu_rw=0: go WDONE.
  - SETUP
    - prom_ce_n=0, prom_oe_n=1.
    - Load counter=WAIT_STATES-1, go ACCESS.
  - ACCESS
    - prom_ce_n=0, prom_oe_n=0.
    - Decrement the counter each cycle. When the counter=0, latch cpu_data_out<={prom_hi_d,prom_lo_d} and go ACK.
  - ACK
    - prom_ce_n=0, prom_oe_n=0, cpu_data_oe=1, cpu_dtack_n=0.
    - Hold until cpu_as_n=1, then go IDLE. In that IDLE cycle dtack_n, oe_n, ce_n and data_oe return to 1/1/1/0.
  - WDONE
    - Write cycle; PROM is never enabled.
    - cpu_dtack_n=0 until cpu_as_n=1, then IDLE. Write data is ignored.
- Latency, read: AS sampled low in IDLE at edge 0 -> CE low after edge 1 -> OE low after edge 2 -> data latched at edge 2+WAIT_STATES -> DTACK low from that edge.
- Total read latency = WAIT_STATES+2 clk edges.
- Byte strobes: both bytes are always read and latched. UDS/LDS only qualify cycle start; the CPU selects the byte lane.
- cpu_data_out holds its last latched value between cycles and is changed only at a latch.
- AS deasserting before ACK (aborted cycle) while in SETUP or ACCESS: return to IDLE next edge, no latch, no DTACK.
- prom_sel dropping mid-cycle is ignored; only AS ends the cycle.
- Back-to-back cycles: a new start is recognised only in IDLE, so at least one IDLE cycle separates consecutive DTACKs.
- prom_addr holds its value outside cycles.

Optional Feature:
- Macro: BOOTPROM_WRITE_BERR_EN.
- Defined: a write to the PROM region goes to WERR instead of WDONE.
  - WERR drives cpu_berr_n=0 and cpu_dtack_n=1 until cpu_as_n=1, then IDLE.
- Undefined: writes are acknowledged silently via WDONE.
  - cpu_berr_n is tied to 1.

Test Plan:
- Reset mid-ACCESS (addr 15'h0123): assert reset -> prom_ce_n=1, prom_oe_n=1, cpu_dtack_n=1 combinationally; state=IDLE after release.
- Read, WAIT_STATES=3, cpu_addr=15'h0004, lo=8'h4E, hi=8'hF9 -> cpu_dtack_n low 5 edges after AS, cpu_data_out=16'hF94E, prom_addr=15'h0004.
- AS released after 2 edges of a read -> no DTACK, cpu_data_out keeps its previous value, CE/OE high the next edge.
- Two back-to-back reads at 15'h0000 then 15'h7FFF -> each returns correct data, with one IDLE cycle between the DTACK pulses.
- Write to the PROM region:
  - Macro undefined -> DTACK after 1 edge, CE_n stays 1.
  - BOOTPROM_WRITE_BERR_EN defined -> cpu_berr_n=0, cpu_dtack_n=1 until AS released.
- Read with prom_sel=0 -> no PROM activity, DTACK stays 1.
